serial_rx_mmio: RTL and testbench

SERIAL_RX_MMIO -- requirements
Module: serial_rx_mmio

---
 rtl/serial_rx_mmio.sv | 188 ++++++++++++++++++
 tb/tb_serial_rx_mmio.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_mmio.sv
// UART receiver (8N1, 2-flop synchronized line) feeding a small byte FIFO,
// exposed to the hart as a read-only MMIO data register and status register.
module serial_rx_mmio #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] DATA_ADDR    = 32'h0003000C,
    parameter logic [31:0] STATUS_ADDR  = 32'h00030010
) (
    input  logic        core_clock,
    input  logic        reset,
    input  logic        serial_rx,
    input  logic [31:0] rd_addr,
    input  logic        rd_enable,
    output logic [31:0] rd_data,
    output logic        rx_not_empty
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    logic               sync_1;
    logic               sync_2;
    logic               line_prev;
    logic               line;
    logic               line_fall;

    rx_state_t          state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_reg;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic               framing_err;
    logic               rd_enable_q;

    logic               stop_sample;
    logic               push_req;
    logic               frame_bad;
    logic               rd_event;
    logic               data_hit;
    logic               status_hit;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               overflow_set;
    logic               status_clear;

    // Line synchronizer; line_prev gives the edge detector its history, so a
    // line that stays low after a bad stop bit cannot retrigger reception.
    always_ff @(posedge core_clock) begin
        if (reset) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_1    <= serial_rx;
            sync_2    <= sync_1;
            line_prev <= sync_2;
        end
    end

    assign line      = sync_2;
    assign line_fall = line_prev & ~line;

    always_ff @(posedge core_clock) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (line_fall) state <= START;
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        state <= line ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer   <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data bits arrive LSB first, so shift toward bit 0.
    always_ff @(posedge core_clock) begin
        if (state == DATA && timer == BIT_LAST) shift_reg <= {line, shift_reg[7:1]};
    end

    assign stop_sample = (state == STOP) && (timer == BIT_LAST);
    assign push_req    = stop_sample & line;
    assign frame_bad   = stop_sample & ~line;

    assign rd_event     = rd_enable & ~rd_enable_q;
    assign data_hit     = (rd_addr == DATA_ADDR);
    assign status_hit   = (rd_addr == STATUS_ADDR);
    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CNT_FULL);
    assign pop          = rd_event & data_hit & ~fifo_empty;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push         = push_req & (~fifo_full | pop);
    assign overflow_set = push_req & fifo_full & ~pop;
    assign status_clear = rd_event & status_hit;

    always_ff @(posedge core_clock) begin
        if (reset) begin
            rd_enable_q <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            rd_enable_q <= rd_enable;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (overflow_set)      overflow <= 1'b1;
            else if (status_clear) overflow <= 1'b0;
            if (frame_bad)         framing_err <= 1'b1;
            else if (status_clear) framing_err <= 1'b0;
        end
    end

    always_ff @(posedge core_clock) begin
        if (push) fifo_mem[wr_ptr] <= shift_reg;
    end

    always_comb begin
        rd_data = 32'h0;
        if (rd_enable) begin
            if (data_hit) begin
                rd_data = fifo_empty ? 32'hFFFF_FFFF : {24'h0, fifo_mem[rd_ptr]};
            end else if (status_hit) begin
                rd_data = {29'h0, framing_err, overflow, ~fifo_empty};
            end
        end
    end

    assign rx_not_empty = ~fifo_empty;

endmodule

// File: tb/tb_serial_rx_mmio.sv
// Bench for serial_rx_mmio: directed scenarios plus randomized frames checked
// against a queue-based model of the receive FIFO and sticky flags.
module tb_serial_rx_mmio;

    localparam int          CPB    = 4;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] DATA_A = 32'h0003000C;
    localparam logic [31:0] STAT_A = 32'h00030010;

    logic        core_clock = 1'b0;
    logic        reset;
    logic        serial_rx;
    logic [31:0] rd_addr;
    logic        rd_enable;
    logic [31:0] rd_data;
    logic        rx_not_empty;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] model_q[$];
    logic       m_ovf;
    logic       m_ferr;

    serial_rx_mmio #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .DATA_ADDR   (DATA_A),
        .STATUS_ADDR (STAT_A)
    ) dut (
        .core_clock  (core_clock),
        .reset       (reset),
        .serial_rx   (serial_rx),
        .rd_addr     (rd_addr),
        .rd_enable   (rd_enable),
        .rd_data     (rd_data),
        .rx_not_empty(rx_not_empty)
    );

    always #5 core_clock = ~core_clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge core_clock);
            #1;
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_status(output logic [31:0] e);
        e      = {29'h0, m_ferr, m_ovf, (model_q.size() != 0)};
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_data(output logic [31:0] e);
        if (model_q.size() != 0) e = {24'h0, model_q.pop_front()};
        else                     e = 32'hFFFF_FFFF;
    endtask

    task automatic drive_bit(input logic b);
        serial_rx = b;
        tick(CPB);
    endtask

    // One 8N1 frame; a low stop bit may be stretched before the line idles high.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int low_hold_bits);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (!stop_ok) repeat (low_hold_bits) drive_bit(1'b0);
        repeat (3) drive_bit(1'b1);
        if (!stop_ok)                    m_ferr = 1'b1;
        else if (model_q.size() == DEPTH) m_ovf = 1'b1;
        else                             model_q.push_back(b);
    endtask

    // Single read event: rd_data is sampled mid-cycle, before the pop edge.
    task automatic do_read(input logic [31:0] a, output logic [31:0] v);
        rd_addr   = a;
        rd_enable = 1'b1;
        @(negedge core_clock);
        v = rd_data;
        @(posedge core_clock);
        #1;
        rd_enable = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        tick(3);
        @(negedge core_clock);
        n_cmp++;
        if (rx_not_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_not_empty got=%0b exp=0", rx_not_empty);
        end
        n_cmp++;
        if (rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd_idle got=%h exp=00000000", rd_data);
        end
        @(posedge core_clock);
        #1;
        reset = 1'b0;
        tick(2);
        do_read(STAT_A, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status got=%h exp=00000000", v);
        end
        do_read(DATA_A, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_data_empty got=%h exp=ffffffff", v);
        end
        do_read(32'h0003_0014, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read got=%h exp=00000000", v);
        end
    endtask

    task automatic test_single_byte();
        logic [31:0] v;
        logic [31:0] e;
        send_byte(8'h55, 1'b1, 0);
        do_read(STAT_A, v);
        model_status(e);
        n_cmp++;
        if (v !== e || v !== 32'h1) begin
            n_fail++;
            $display("FAIL single_status got=%h exp=%h", v, e);
        end
        do_read(DATA_A, v);
        model_data(e);
        n_cmp++;
        if (v !== e || v !== 32'h55) begin
            n_fail++;
            $display("FAIL single_data got=%h exp=%h", v, e);
        end
        do_read(STAT_A, v);
        model_status(e);
        n_cmp++;
        if (v !== e || v !== 32'h0) begin
            n_fail++;
            $display("FAIL single_status2 got=%h exp=%h", v, e);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        logic [31:0] e;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 0);
        do_read(STAT_A, v);
        model_status(e);
        n_cmp++;
        if (v !== e || v !== 32'h3) begin
            n_fail++;
            $display("FAIL ovf_status got=%h exp=%h", v, e);
        end
        for (int i = 1; i <= 5; i++) begin
            do_read(DATA_A, v);
            model_data(e);
            n_cmp++;
            if (v !== e) begin
                n_fail++;
                $display("FAIL ovf_data%0d got=%h exp=%h", i, v, e);
            end
        end
        do_read(STAT_A, v);
        model_status(e);
        n_cmp++;
        if (v !== e || v !== 32'h0) begin
            n_fail++;
            $display("FAIL ovf_status2 got=%h exp=%h", v, e);
        end
    endtask

    task automatic test_framing();
        logic [31:0] v;
        logic [31:0] e;
        send_byte(8'hA3, 1'b0, 3);
        n_cmp++;
        if (rx_not_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_not_empty got=%0b exp=0", rx_not_empty);
        end
        do_read(STAT_A, v);
        model_status(e);
        n_cmp++;
        if (v !== e || v !== 32'h4) begin
            n_fail++;
            $display("FAIL frame_status got=%h exp=%h", v, e);
        end
        send_byte(8'h3C, 1'b1, 0);
        do_read(DATA_A, v);
        model_data(e);
        n_cmp++;
        if (v !== e || v !== 32'h3C) begin
            n_fail++;
            $display("FAIL frame_recover got=%h exp=%h", v, e);
        end
        do_read(STAT_A, v);
        model_status(e);
        n_cmp++;
        if (v !== e) begin
            n_fail++;
            $display("FAIL frame_status2 got=%h exp=%h", v, e);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        logic [31:0] e;
        serial_rx = 1'b0;
        tick(1);
        serial_rx = 1'b1;
        tick(12 * CPB);
        do_read(STAT_A, v);
        model_status(e);
        n_cmp++;
        if (v !== e || v !== 32'h0) begin
            n_fail++;
            $display("FAIL glitch_status got=%h exp=%h", v, e);
        end
    endtask

    task automatic test_held_read();
        logic [31:0] v;
        logic [31:0] e;
        send_byte(8'hC1, 1'b1, 0);
        send_byte(8'hC2, 1'b1, 0);
        rd_addr   = DATA_A;
        rd_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge core_clock);
            e = (i == 0) ? 32'hC1 : 32'hC2;
            n_cmp++;
            if (rd_data !== e) begin
                n_fail++;
                $display("FAIL held_cycle%0d got=%h exp=%h", i, rd_data, e);
            end
            @(posedge core_clock);
            #1;
        end
        rd_enable = 1'b0;
        void'(model_q.pop_front());
        tick(1);
        n_cmp++;
        if (rx_not_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL held_not_empty got=%0b exp=1", rx_not_empty);
        end
        do_read(DATA_A, v);
        model_data(e);
        n_cmp++;
        if (v !== e || v !== 32'hC2) begin
            n_fail++;
            $display("FAIL held_second got=%h exp=%h", v, e);
        end
        do_read(DATA_A, v);
        model_data(e);
        n_cmp++;
        if (v !== e) begin
            n_fail++;
            $display("FAIL held_drained got=%h exp=%h", v, e);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        logic [31:0] e;
        logic [7:0]  b;
        send_byte(8'h11, 1'b1, 0);
        b = 8'h6B;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        serial_rx = b[4];
        tick(2);
        reset     = 1'b1;
        serial_rx = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(12 * CPB);
        n_cmp++;
        if (rx_not_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_not_empty got=%0b exp=0", rx_not_empty);
        end
        do_read(STAT_A, v);
        model_status(e);
        n_cmp++;
        if (v !== e || v !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_status got=%h exp=%h", v, e);
        end
        send_byte(8'h7E, 1'b1, 0);
        do_read(DATA_A, v);
        model_data(e);
        n_cmp++;
        if (v !== e || v !== 32'h7E) begin
            n_fail++;
            $display("FAIL midreset_next got=%h exp=%h", v, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [31:0] e;
        logic [7:0]  b;
        logic        ok;
        int          r;
        for (int n = 0; n < 24; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_byte(b, ok, $urandom_range(0, 2));
            r = $urandom_range(0, 3);
            if (r == 0) begin
                do_read(DATA_A, v);
                model_data(e);
                n_cmp++;
                if (v !== e) begin
                    n_fail++;
                    $display("FAIL rand_data%0d got=%h exp=%h", n, v, e);
                end
            end else if (r == 1) begin
                do_read(STAT_A, v);
                model_status(e);
                n_cmp++;
                if (v !== e) begin
                    n_fail++;
                    $display("FAIL rand_status%0d got=%h exp=%h", n, v, e);
                end
            end
        end
        for (int n = 0; n < DEPTH + 1; n++) begin
            do_read(DATA_A, v);
            model_data(e);
            n_cmp++;
            if (v !== e) begin
                n_fail++;
                $display("FAIL rand_drain%0d got=%h exp=%h", n, v, e);
            end
        end
        do_read(STAT_A, v);
        model_status(e);
        n_cmp++;
        if (v !== e) begin
            n_fail++;
            $display("FAIL rand_final_status got=%h exp=%h", v, e);
        end
    endtask

    initial begin
        reset     = 1'b1;
        serial_rx = 1'b1;
        rd_addr   = 32'h0;
        rd_enable = 1'b0;
        model_reset();
        tick(1);
        test_reset();
        test_single_byte();
        test_overflow();
        test_framing();
        test_glitch();
        test_held_read();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
